piezo_tune_seq: RTL

PIEZO_TUNE_SEQ -- requirements
Module: piezo_tune_seq

---
 rtl/piezo_tune_seq.sv | 110 +++++++++++
 1 files changed

// File: rtl/piezo_tune_seq.sv
// Six-note piezo tune sequencer: walks a fixed period/duration table and drives
// a downstream frequency counter with the current note period and a clear strobe.
module piezo_tune_seq #(
  parameter int          FAST_SIM = 0,
  parameter int unsigned SIM_STEP = 0   // nonzero overrides the duration step (must divide 2^22)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic        stop,
  output logic [14:0] note_per,
  output logic        clr,
  output logic        busy,
  output logic        done
);

  localparam int unsigned STEP   = (SIM_STEP != 0) ? SIM_STEP : ((FAST_SIM != 0) ? 64 : 1);
  localparam logic [25:0] STEP_W = 26'(STEP);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t      state, state_n;
  logic [2:0]  idx, idx_n;
  logic [25:0] dur, dur_n, dur_sum;
  logic        done_n;

  function automatic logic [14:0] per_of(input logic [2:0] i);
    case (i)
      3'd0:    return 15'd31888;
      3'd1:    return 15'd23889;
      3'd2:    return 15'd18961;
      3'd3:    return 15'd15944;
      3'd4:    return 15'd18961;
      3'd5:    return 15'd15944;
      default: return '0;
    endcase
  endfunction

  function automatic logic [25:0] dur_of(input logic [2:0] i);
    case (i)
      3'd0, 3'd1, 3'd2: return 26'h0800000;  // 2^23
      3'd3:             return 26'h0C00000;  // 2^23 + 2^22
      3'd4:             return 26'h0400000;  // 2^22
      3'd5:             return 26'h2000000;  // 2^25
      default:          return 26'h0400000;
    endcase
  endfunction

  assign dur_sum = dur + STEP_W;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    dur_n   = dur;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (go && !stop) begin
          state_n = PLAY;
          idx_n   = '0;
          dur_n   = '0;
        end
      end
      PLAY: begin
        if (stop) begin
          state_n = IDLE;
          idx_n   = '0;
          dur_n   = '0;
        end else if (dur_sum < dur_of(idx)) begin
          dur_n = dur_sum;
        end else if (idx < 3'd5) begin
          idx_n = idx + 3'd1;
          dur_n = '0;
        end else begin
          state_n = IDLE;
          idx_n   = '0;
          dur_n   = '0;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
        dur_n   = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state values so they line up with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      dur      <= '0;
      done     <= 1'b0;
      note_per <= '0;
      clr      <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      dur      <= dur_n;
      done     <= done_n;
      note_per <= (state_n == PLAY) ? per_of(idx_n) : '0;
      clr      <= (state_n == IDLE) || (dur_n == '0);
      busy     <= (state_n == PLAY);
    end
  end

endmodule
